// File: rtl/cfg_reg_bank_pkg.sv
// Shared definitions for the configuration register bank: transaction FSM
// state encoding used by the top level.
package cfg_reg_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

endpackage

// File: rtl/cfg_reg_bank_if.sv
// Request/acknowledge bus between a configuration master and the register
// bank. The master raises sel_en and holds it until it has seen ack.
interface cfg_reg_bank_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) ();

  logic              sel_en;
  logic              wr_rd_s;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ack;
  logic              err;

  modport master (
    output sel_en, wr_rd_s, addr, wr_data,
    input  rd_data, ack, err
  );

  modport slave (
    input  sel_en, wr_rd_s, addr, wr_data,
    output rd_data, ack, err
  );

endinterface

// File: rtl/cfg_reg_bank_cell.sv
// One configuration register: DATA_W flops with a load enable, reset to
// RST_VAL. Read-only registers are built from this cell with load tied low.
module cfg_reg_cell #(
  parameter int                 DATA_W  = 8,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Hold the register value; load new data when enabled.
  // NOTE: these are a handful of config flops, not a RAM macro, so giving them
  // an async reset is cheap and guarantees the datapath sees RST_VAL at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless
      // of the order in which always_ff blocks are evaluated.
      q <= d;
    end
  end

endmodule

// File: rtl/cfg_reg_bank.sv
// Parametrised configuration register bank. A registered request/ack FSM
// serves one read or write per sel_en assertion and flags illegal accesses
// (out-of-range address, write to a read-only register) with err. All
// register contents are exported on mem_out, with a one-cycle upd strobe
// for each register that was written.
module cfg_reg_bank
  import cfg_reg_pkg::*;
#(
  parameter int                     DATA_W     = 8,
  parameter int                     ADDR_W     = 8,
  parameter int                     NUM_OF_REG = 4,
  parameter logic [DATA_W-1:0]      RST_VAL    = '0,
  parameter logic [NUM_OF_REG-1:0]  RO_MASK    = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  cfg_reg_bank_if.slave                        bus,
  output logic [NUM_OF_REG-1:0][DATA_W-1:0]    mem_out,
  output logic [NUM_OF_REG-1:0]                upd
);

  state_t                  state;
  logic                    ack_q;
  logic                    err_q;
  logic [DATA_W-1:0]       rd_data_q;

  logic [NUM_OF_REG-1:0]   sel_vec;
  logic [DATA_W-1:0]       rd_mux;
  logic                    addr_ok;
  logic                    ro_hit;
  logic                    wr_ok;
  logic                    bad_access;
  logic                    wr_fire;

  // Address decode at full ADDR_W width: one-hot select and read mux.
  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    sel_vec = '0;
    rd_mux  = '0;
    for (int i = 0; i < NUM_OF_REG; i++) begin
      if (bus.addr == ADDR_W'(i)) begin
        sel_vec[i] = 1'b1;
        rd_mux     = mem_out[i];
      end
    end
  end

  // An address matching no register is out of range; no wrap is possible.
  assign addr_ok    = |sel_vec;
  assign ro_hit     = |(sel_vec & RO_MASK);
  assign wr_ok      = bus.wr_rd_s && addr_ok && !ro_hit;
  assign bad_access = !addr_ok || (bus.wr_rd_s && ro_hit);
  assign wr_fire    = (state == IDLE) && bus.sel_en && wr_ok;

  // Register storage; read-only entries can never load and keep RST_VAL.
  for (genvar i = 0; i < NUM_OF_REG; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      cfg_reg_cell #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (1'b0),
        .d     (bus.wr_data),
        .q     (mem_out[i])
      );
    end else begin : g_rw
      cfg_reg_cell #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (wr_fire && sel_vec[i]),
        .d     (bus.wr_data),
        .q     (mem_out[i])
      );
    end
  end

  // Transaction FSM with registered ack/err/rd_data/upd; accepts a request
  // only in IDLE, so a held sel_en produces a single transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      upd       <= '0;
    end else begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      upd       <= '0;
      case (state)
        IDLE: begin
          if (bus.sel_en) begin
            state     <= ACK;
            ack_q     <= 1'b1;
            err_q     <= bad_access;
            rd_data_q <= (!bus.wr_rd_s && addr_ok) ? rd_mux : '0;
            upd       <= wr_ok ? sel_vec : '0;
          end
        end
        ACK:      state <= bus.sel_en ? WAIT_REL : IDLE;
        WAIT_REL: if (!bus.sel_en) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Bench for cfg_reg_bank. Two configurations share one stimulus stream:
//   dut_a: 8-bit data, 4 registers, RST_VAL=0xA5, register 0 read-only
//   dut_b: 16-bit data, 8 registers, RST_VAL=0, all writable
// Each issued request pushes the expected response of each configuration
// into its queue; per-DUT monitors pop and compare whenever ack is seen.
module tb_cfg_reg_bank;

  typedef struct packed {
    logic            err;
    logic [7:0]      rd;
    logic [3:0]      upd;
    logic [3:0][7:0] mem;
  } exp_a_t;

  typedef struct packed {
    logic             err;
    logic [15:0]      rd;
    logic [7:0]       upd;
    logic [7:0][15:0] mem;
  } exp_b_t;

  localparam logic [7:0]  A_RST = 8'hA5;
  localparam logic [3:0]  A_RO  = 4'b0001;
  localparam logic [15:0] B_RST = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel_en;
  logic        wr_rd_s;
  logic [7:0]  addr;
  logic [15:0] wr_data;
  logic        run;

  logic [3:0][7:0]  mem_a;
  logic [3:0]       upd_a;
  logic [7:0][15:0] mem_b;
  logic [7:0]       upd_b;

  int n_checks = 0;
  int n_errors = 0;

  exp_a_t q_a[$];
  exp_b_t q_b[$];

  // Reference state: plain arrays of register values.
  logic [7:0]  ref_a[4];
  logic [15:0] ref_b[8];

  always #5 clk = ~clk;

  cfg_reg_bank_if #(.DATA_W(8),  .ADDR_W(8)) bus_a ();
  cfg_reg_bank_if #(.DATA_W(16), .ADDR_W(8)) bus_b ();

  assign bus_a.sel_en  = sel_en;
  assign bus_a.wr_rd_s = wr_rd_s;
  assign bus_a.addr    = addr;
  assign bus_a.wr_data = wr_data[7:0];
  assign bus_b.sel_en  = sel_en;
  assign bus_b.wr_rd_s = wr_rd_s;
  assign bus_b.addr    = addr;
  assign bus_b.wr_data = wr_data;

  cfg_reg_bank #(
    .DATA_W(8), .ADDR_W(8), .NUM_OF_REG(4), .RST_VAL(A_RST), .RO_MASK(A_RO)
  ) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_a),
    .mem_out (mem_a),
    .upd     (upd_a)
  );

  cfg_reg_bank #(
    .DATA_W(16), .ADDR_W(8), .NUM_OF_REG(8), .RST_VAL(B_RST), .RO_MASK(8'h00)
  ) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_b),
    .mem_out (mem_b),
    .upd     (upd_b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] snap_a();
    logic [3:0][7:0] m;
    for (int i = 0; i < 4; i++) m[i] = ref_a[i];
    return m;
  endfunction

  function automatic logic [127:0] snap_b();
    logic [7:0][15:0] m;
    for (int i = 0; i < 8; i++) m[i] = ref_b[i];
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_a[i] = A_RST;
    for (int i = 0; i < 8; i++) ref_b[i] = B_RST;
  endtask

  // Apply one request to both reference models and queue the responses.
  task automatic model_issue(input bit wr, input int a, input logic [15:0] d);
    exp_a_t ea;
    exp_b_t eb;
    ea = '0;
    eb = '0;
    if (a >= 4 || (wr && A_RO[a % 4])) begin
      ea.err = 1'b1;
    end else if (wr) begin
      ref_a[a]  = d[7:0];
      ea.upd[a] = 1'b1;
    end else begin
      ea.rd = ref_a[a];
    end
    ea.mem = snap_a();
    if (a >= 8) begin
      eb.err = 1'b1;
    end else if (wr) begin
      ref_b[a]  = d;
      eb.upd[a] = 1'b1;
    end else begin
      eb.rd = ref_b[a];
    end
    eb.mem = snap_b();
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  // Called just after a negedge with the bank idle; returns just after a
  // negedge with the bank idle again. hold = cycles sel_en stays high.
  task automatic do_txn(input bit wr, input int a, input logic [15:0] d, input int hold);
    model_issue(wr, a, d);
    wr_rd_s = wr;
    addr    = 8'(a);
    wr_data = d;
    sel_en  = 1'b1;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    sel_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("a_ack_missing", 128'(q_a.size()), 128'd0);
    check("b_ack_missing", 128'(q_b.size()), 128'd0);
    q_a.delete();
    q_b.delete();
  endtask

  // Monitor for configuration A.
  always @(negedge clk) begin
    exp_a_t e;
    if (run && rst_n) begin
      if (bus_a.ack) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_ack", 128'(bus_a.ack), 128'd0);
        end else begin
          e = q_a.pop_front();
          check("a_err",     128'(bus_a.err),     128'(e.err));
          check("a_rd_data", 128'(bus_a.rd_data), 128'(e.rd));
          check("a_upd",     128'(upd_a),         128'(e.upd));
          check("a_mem_out", 128'(mem_a),         128'(e.mem));
        end
      end else begin
        check("a_idle_rd_data", 128'(bus_a.rd_data), 128'd0);
        check("a_idle_upd",     128'(upd_a),         128'd0);
      end
    end
  end

  // Monitor for configuration B.
  always @(negedge clk) begin
    exp_b_t e;
    if (run && rst_n) begin
      if (bus_b.ack) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_ack", 128'(bus_b.ack), 128'd0);
        end else begin
          e = q_b.pop_front();
          check("b_err",     128'(bus_b.err),     128'(e.err));
          check("b_rd_data", 128'(bus_b.rd_data), 128'(e.rd));
          check("b_upd",     128'(upd_b),         128'(e.upd));
          check("b_mem_out", 128'(mem_b),         128'(e.mem));
        end
      end else begin
        check("b_idle_rd_data", 128'(bus_b.rd_data), 128'd0);
        check("b_idle_upd",     128'(upd_b),         128'd0);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_a_ack"},     128'(bus_a.ack),     128'd0);
    check({tag, "_a_err"},     128'(bus_a.err),     128'd0);
    check({tag, "_a_rd_data"}, 128'(bus_a.rd_data), 128'd0);
    check({tag, "_a_upd"},     128'(upd_a),         128'd0);
    check({tag, "_a_mem_out"}, 128'(mem_a),         128'h00000000_00000000_00000000_A5A5A5A5);
    check({tag, "_b_ack"},     128'(bus_b.ack),     128'd0);
    check({tag, "_b_upd"},     128'(upd_b),         128'd0);
    check({tag, "_b_mem_out"}, 128'(mem_b),         128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;
    int          a;
    rst_n   = 1'b0;
    sel_en  = 1'b0;
    wr_rd_s = 1'b0;
    addr    = '0;
    wr_data = '0;
    run     = 1'b0;
    model_reset();

    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_txn(1'b1, 2,    16'h003C, 1);   // write 0x3C to reg 2
    do_txn(1'b0, 2,    16'h0000, 1);   // read it back
    do_txn(1'b1, 4,    16'h0011, 1);   // out of range for A, legal for B
    do_txn(1'b0, 4,    16'h0000, 1);
    do_txn(1'b0, 8'hFF, 16'h0000, 1);  // out of range for both
    do_txn(1'b1, 0,    16'h0077, 1);   // read-only in A
    do_txn(1'b0, 0,    16'h0000, 1);
    do_txn(1'b1, 1,    16'h5A5A, 6);   // held request: single ack/upd
    do_txn(1'b1, 7,    16'hBEEF, 1);   // A: illegal; B: last register
    do_txn(1'b0, 7,    16'h0000, 1);
    do_txn(1'b1, 8,    16'h1234, 1);   // first out-of-range address for B

    // Write aborted by reset during its ack cycle.
    wr_rd_s = 1'b1;
    addr    = 8'd3;
    wr_data = 16'hC3C3;
    sel_en  = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("abort");
    sel_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(1'b0, 3, 16'h0000, 1);      // register 3 back at reset value

    // Randomised traffic.
    for (int n = 0; n < 80; n++) begin
      a = $urandom_range(0, 9);
      if (a == 9) a = $urandom_range(0, 255);
      d = 16'($urandom);
      do_txn(1'($urandom_range(0, 1)), a, d, $urandom_range(1, 3));
    end

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
